// File: rtl/cp_out_responder_pkg.sv
// cp_out_responder_pkg: shared types and constants for the control-plane output responder.
`default_nettype none

package cp_out_responder_pkg;

    localparam int TEST_CP_OUT_ADDR_WIDTH = 21;
    localparam int TEST_CP_IN_DATA_WIDTH  = 20;
    localparam int ERR_CNT_WIDTH          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } cp_rsp_state_t;

    typedef struct packed {
        logic                              write;
        logic [TEST_CP_OUT_ADDR_WIDTH-1:0] addr;
        logic [TEST_CP_IN_DATA_WIDTH-1:0]  wdata;
    } cp_req_t;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp_out_responder_reg_array.sv
// cp_reg_array: DEPTH x DATA_WIDTH register file, async clear, one write port, one combinational read port.
`default_nettype none

module cp_reg_array #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 20,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/cp_out_responder.sv
// cp_out_responder: register-backed target for control_plane_out requests, one transaction outstanding.
// Optional error counter enabled by defining CP_OUT_RESPONDER_ERR_CNT_EN.
`default_nettype none

module cp_out_responder
    import cp_out_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = TEST_CP_OUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = TEST_CP_IN_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int                    IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [1:0]            LAT_INIT = 2'(RD_LATENCY - 1);

    cp_rsp_state_t         state_q, state_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  ready_q;

    logic                  accept;
    logic                  in_range;
    logic                  arr_we;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    // Full-width compare so high address bits never alias onto the array.
    assign in_range = (req_addr < DEPTH_A);
    assign accept   = req_valid && ready_q;
    assign arr_we   = accept && req_write && in_range;
    assign rd_idx   = (state_q == IDLE) ? req_addr[IDX_W-1:0] : idx_q;

    cp_reg_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_reg_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .waddr_i (req_addr[IDX_W-1:0]),
        .wdata_i (req_wdata),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d = req_addr[IDX_W-1:0];
                    if (req_write || !in_range) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = !in_range;
                    end else if (RD_LATENCY == 1) begin
                        state_d = RESP;
                        rdata_d = rd_data;
                        err_d   = 1'b0;
                    end else begin
                        state_d   = WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                // Counter reaching zero on this edge means the response is due next cycle.
                lat_cnt_d = lat_cnt_q - 2'd1;
                if (lat_cnt_q == 2'd1) begin
                    state_d = RESP;
                    rdata_d = rd_data;
                    err_d   = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            // Registered ready stays low through reset and rises one edge after release.
            ready_q   <= (state_d == IDLE);
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef CP_OUT_RESPONDER_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready && err_q) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cp_out_responder.md
Name: cp_out_responder

Overview:
- Target end of the block_b control-plane output interface: accepts read/write requests issued on control_plane_out and returns responses.
- Backs requests with a small internal register array; out-of-range addresses get an error response.
- Used as the HDL-side responder in block-level benches and as a stub target in integration.

Parameters:
- ADDR_WIDTH, 21, request address width; matches TEST_CP_OUT_ADDR_WIDTH.
- DATA_WIDTH, 20, read/write data width; matches TEST_CP_IN_DATA_WIDTH.
- DEPTH, 16, number of implemented registers (power of 2, 2..256); the valid address range is 0..DEPTH-1.
- RD_LATENCY, 2, cycles from request accept to response valid for reads (1..4); writes always take 1 cycle.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, responder can accept a request.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_WIDTH, register address.
- req_wdata, in, DATA_WIDTH, write data.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, initiator accepts the response.
- rsp_rdata, out, DATA_WIDTH, read data; 0 for writes and errors.
- rsp_err, out, 1, address out of range.
- err_count, out, 16, count of error responses issued (see Optional Feature).

Behaviour:
- Reset (async assert, sync release) sets:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0.
  - All registers cleared to 0.
  - FSM in IDLE.
  - Reset mid-transaction discards the request in flight.
- Handshakes:
  - A request transfers when req_valid && req_ready.
  - A response transfers when rsp_valid && rsp_ready.
  - rsp_valid, rsp_rdata and rsp_err hold stable until the response transfers.
  - Only one transaction is outstanding at a time.
- FSM states:
  - IDLE: req_ready=1. On accept, latch write/addr/wdata.
    - Write, or out-of-range address -> RESP.
    - Read in range -> WAIT with lat_cnt=RD_LATENCY-1.
  - WAIT: req_ready=0. lat_cnt decrements each cycle; at 0 -> RESP. Read data is sampled from the array on entry to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_ready -> IDLE.
- Response timing:
  - rsp_valid asserts 1 cycle after accept for writes and errors.
  - rsp_valid asserts RD_LATENCY cycles after accept for in-range reads.
  - Back-to-back throughput is one transaction per (latency + 1) cycles minimum, because IDLE is re-entered for one cycle.
- Address decode:
  - In range iff req_addr < DEPTH, compared across all ADDR_WIDTH bits; no aliasing.
  - An out-of-range write does not modify the array. The response carries rsp_err=1 and rsp_rdata=0.
- Write commit: the array updates in the accept cycle, so a following read returns the new value.
- Stalls: rsp_ready held low keeps the FSM in RESP indefinitely, with no request accepted.
- Boundary: req_addr = DEPTH-1 is valid; req_addr = DEPTH is an error; all-ones address is an error.

Optional Feature:
- Macro: CP_OUT_RESPONDER_ERR_CNT_EN.
- Defined: err_count increments on each error-response transfer and saturates at 16'hFFFF.
- Undefined: err_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Package cp_out_responder_pkg holds:
  - typedef enum {IDLE, WAIT, RESP} cp_rsp_state_t.
  - Constant ERR_CNT_WIDTH = 16.
  - A request struct type {write, addr, wdata} parameterised by the widths from the test parameters package.
- Natural sub-module: cp_reg_array, a DEPTH x DATA_WIDTH register array with async clear, one write port and one combinational read port.

Test Plan:
- Write addr 3 data 20'hABCDE, rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_err=0, rsp_rdata=0. Then read addr 3 -> rsp_rdata=20'hABCDE, 2 cycles after accept.
- Read addr 16 (DEPTH=16) and write addr 21'h1FFFFF -> both rsp_err=1, rsp_rdata=0. A later read of addr 0 returns 0. err_count=2 with the macro defined, 0 without.
- Read addr 15, rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready=0. Transfer on cycle 11, req_ready=1 the next cycle.
- req_valid continuously high with 4 writes to addrs 0..3 -> each accepted every 2 cycles (IDLE->RESP->IDLE). All 4 values read back correctly.
- Assert rst while in WAIT -> rsp_valid=0 and req_ready=0 immediately. After release, reading the previously written addr returns 0.
- RD_LATENCY=4 build: read addr 1 -> rsp_valid asserts exactly 4 cycles after accept.
